// File: rtl/uart_print_sched.sv
// Round-robin scheduler that shares one uart_tx among N_REQ byte-stream producers.
// Optional UART_SCHED_TIMEOUT_EN: release a grant whose owner stays idle for TIMEOUT_CYC cycles.
module uart_print_sched #(
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_last,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     msg_done,
  input  logic                 tx_busy,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [1:0]           state_dbg
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("uart_print_sched: N_REQ must be 2..8 and TIMEOUT_CYC 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_XFER    = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [N_REQ-1:0] grant_d;
  logic [IW-1:0]    gidx, gidx_d;
  logic [IW-1:0]    rr_ptr, rr_ptr_d;
  logic             last_q, last_d;
  logic             tx_start_d;
  logic [7:0]       tx_data_d;
  logic             accept;
  logic [7:0]       sel_data;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [IW:0]      cand_sum;
  logic [IW-1:0]    cand;
`ifdef UART_SCHED_TIMEOUT_EN
  logic [15:0]      to_cnt, to_cnt_d;
`endif

  // Handshake: requester i's byte transfers on a cycle with req_valid[i] & req_ready[i];
  // req_ready never depends on req_valid, only on grant, state and tx_busy.
  assign req_ready = (state == S_XFER && !tx_busy) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign msg_done  = (state == S_RELEASE) ? grant : '0;
  assign sel_data  = req_data[{gidx, 3'b000} +: 8];
  assign state_dbg = state;

  // First requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand_sum >= (IW+1)'(N_REQ)) cand_sum = cand_sum - (IW+1)'(N_REQ);
      cand = cand_sum[IW-1:0];
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state;
    grant_d    = grant;
    gidx_d     = gidx;
    rr_ptr_d   = rr_ptr;
    last_d     = last_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
`ifdef UART_SCHED_TIMEOUT_EN
    to_cnt_d   = to_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          last_d            = 1'b0;
          state_d           = S_XFER;
`ifdef UART_SCHED_TIMEOUT_EN
          to_cnt_d          = '0;
`endif
        end
      end
      S_XFER: begin
        if (accept) begin
          tx_data_d  = sel_data;
          tx_start_d = 1'b1;
          last_d     = req_last[gidx];
          state_d    = S_HOLD;
`ifdef UART_SCHED_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end else if (!req[gidx]) begin
          state_d = S_RELEASE;
        end
`ifdef UART_SCHED_TIMEOUT_EN
        else if (!tx_busy && !req_valid[gidx]) begin
          if (to_cnt == 16'(TIMEOUT_CYC - 1)) state_d = S_RELEASE;
          else to_cnt_d = to_cnt + 16'd1;
        end
`endif
      end
      // One dead cycle lets uart_tx raise tx_busy before the next byte can be accepted.
      S_HOLD: begin
        state_d = last_q ? S_RELEASE : S_XFER;
      end
      S_RELEASE: begin
        grant_d  = '0;
        rr_ptr_d = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      grant    <= '0;
      gidx     <= '0;
      rr_ptr   <= '0;
      last_q   <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
`ifdef UART_SCHED_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      gidx     <= gidx_d;
      rr_ptr   <= rr_ptr_d;
      last_q   <= last_d;
      tx_start <= tx_start_d;
      tx_data  <= tx_data_d;
`ifdef UART_SCHED_TIMEOUT_EN
      to_cnt   <= to_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_print_sched.sv
// Directed bench for uart_print_sched: message table, round-robin, stall, abort, timeout, reset.
module tb_uart_print_sched;

  localparam int N        = 3;
  localparam int TO_CYC   = 20;
  localparam int BUSY_LEN = 10;
  localparam int WAIT_MAX = 3000;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [N-1:0]   msg_done;
  logic           tx_busy;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [1:0]     state_dbg;

  int         checks;
  int         errors;
  logic [7:0] exp_q[$];
  int         start_cnt;
  int         done_cnt[N];
  int         busy_cnt;
  logic       busy_force;
  logic       prev_start;

  uart_print_sched #(.N_REQ(N), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant     (grant),
    .msg_done  (msg_done),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // uart_tx model: busy for BUSY_LEN cycles starting the cycle after tx_start
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_busy = busy_force || (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
  end

  // Scoreboard and per-cycle protocol monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        chk("ready_outside_grant", 32'(req_ready & ~grant), 32'd0);
        chk("done_outside_grant", 32'(msg_done & ~grant), 32'd0);
        if (tx_start) begin
          chk("back_to_back_start", 32'(prev_start), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx_start: got %0h expected none", tx_data);
          end else begin
            chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
          end
          busy_cnt = BUSY_LEN;
          start_cnt++;
        end
        for (int i = 0; i < N; i++) if (msg_done[i]) done_cnt[i]++;
        prev_start = tx_start;
      end else begin
        prev_start = 1'b0;
      end
    end
  end

  // Driver tasks (called at posedge+1, return at posedge+1)
  task automatic apply_reset();
    rst_n     = 1'b0;
    req       = '0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int id, input logic [7:0] d, input logic last, output logic ok);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    req_data[8*id +: 8] = d;
    req_last[id]        = last;
    req_valid[id]       = 1'b1;
    while (!acc && n < WAIT_MAX) begin
      @(negedge clk);
      acc = req_ready[id];
      @(posedge clk);
      #1;
      n++;
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
    ok = acc;
    chk($sformatf("accept_req%0d", id), 32'(acc), 32'd1);
  endtask

  task automatic wait_done(input int id);
    logic seen;
    int   n;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < WAIT_MAX) begin
      @(negedge clk);
      seen = msg_done[id];
      n++;
    end
    chk($sformatf("msg_done_req%0d", id), 32'(seen), 32'd1);
  endtask

  task automatic send_msg(input int id, input int len, input logic [39:0] b);
    logic ok;
    req[id] = 1'b1;
    for (int i = 0; i < len; i++) begin
      send_byte(id, b[8*i +: 8], (i == len - 1), ok);
      if (i == len - 1 || !ok) req[id] = 1'b0;
      if (!ok) return;
    end
    wait_done(id);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          id;
    int          len;
    logic [39:0] data;
    int          exp_starts;
    int          exp_done;
  } msg_vec_t;

  msg_vec_t vecs[4];
  int       s0;
  int       d0;
  int       n;
  logic     ok;

  initial begin
    checks     = 0;
    errors     = 0;
    start_cnt  = 0;
    busy_cnt   = 0;
    busy_force = 1'b0;
    prev_start = 1'b0;
    for (int i = 0; i < N; i++) done_cnt[i] = 0;

    vecs[0] = '{0, 3, 40'h00_00_35_09_31, 3, 1};
    vecs[1] = '{1, 2, 40'h00_00_00_A1_A0, 2, 1};
    vecs[2] = '{2, 1, 40'h00_00_00_00_FF, 1, 1};
    vecs[3] = '{1, 5, 40'h05_04_03_02_01, 5, 1};

    // Reset values
    rst_n     = 1'b0;
    req       = '0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    #12;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_msg_done", 32'(msg_done), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    apply_reset();

    // Message table
    for (int v = 0; v < 4; v++) begin
      s0 = start_cnt;
      d0 = done_cnt[vecs[v].id];
      for (int i = 0; i < vecs[v].len; i++) exp_q.push_back(vecs[v].data[8*i +: 8]);
      send_msg(vecs[v].id, vecs[v].len, vecs[v].data);
      chk("vec_tx_starts", 32'(start_cnt - s0), 32'(vecs[v].exp_starts));
      chk("vec_msg_done", 32'(done_cnt[vecs[v].id] - d0), 32'(vecs[v].exp_done));
      chk("vec_grant_idle", 32'(grant), 32'd0);
      chk("vec_queue_drained", 32'(exp_q.size()), 32'd0);
    end

    // Simultaneous requests, two rounds: order 0,1,2 both times
    apply_reset();
    repeat (2) begin
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h42);
      exp_q.push_back(8'h43);
      fork
        send_msg(0, 1, 40'h41);
        send_msg(1, 1, 40'h42);
        send_msg(2, 1, 40'h43);
      join
      chk("rr_queue_drained", 32'(exp_q.size()), 32'd0);
    end

    // tx_busy held high for 100 cycles while a byte waits
    busy_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    s0 = start_cnt;
    exp_q.push_back(8'h77);
    fork
      send_msg(0, 1, 40'h77);
      begin
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          chk("stall_ready", 32'(req_ready[0]), 32'd0);
          chk("stall_no_start", 32'(start_cnt - s0), 32'd0);
          if (c == 50) chk("stall_grant", 32'(grant), 32'b001);
        end
        busy_force = 1'b0;
      end
    join
    chk("stall_sent_once", 32'(start_cnt - s0), 32'd1);

    // Abort: req[1] drops after one byte, pending req[2] follows
    d0 = done_cnt[1];
    req[2] = 1'b1;
    req[1] = 1'b1;
    exp_q.push_back(8'h55);
    send_byte(1, 8'h55, 1'b0, ok);
    req[1] = 1'b0;
    wait_done(1);
    @(negedge clk);
    chk("abort_idle_grant", 32'(grant), 32'd0);
    chk("abort_idle_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    chk("abort_next_grant", 32'(grant), 32'b100);
    chk("abort_done_count", 32'(done_cnt[1] - d0), 32'd1);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h66);
    send_msg(2, 1, 40'h66);

    // Granted requester never presents a byte
    repeat (BUSY_LEN + 2) @(posedge clk);
    #1;
    d0 = done_cnt[0];
    req[0] = 1'b1;
    n = 0;
    while (!grant[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_owner_granted", 32'(grant), 32'b001);
`ifdef UART_SCHED_TIMEOUT_EN
    n = 0;
    while (!msg_done[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_release_cycle", 32'(n), 32'(TO_CYC));
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    @(negedge clk);
    chk("timeout_grant_cleared", 32'(grant), 32'd0);
`else
    repeat (1000) @(negedge clk);
    chk("no_timeout_grant_held", 32'(grant), 32'b001);
    chk("no_timeout_no_done", 32'(done_cnt[0] - d0), 32'd0);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    wait_done(0);
`endif
    @(posedge clk);
    #1;

    // Asynchronous reset after byte 2 of 5, then full resend
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    req[0] = 1'b1;
    send_byte(0, 8'h11, 1'b0, ok);
    send_byte(0, 8'h12, 1'b0, ok);
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    req       = '0;
    req_valid = '0;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    chk("midrst_msg_done", 32'(msg_done), 32'd0);
    chk("midrst_state", 32'(state_dbg), 32'd0);
    chk("midrst_queue", 32'(exp_q.size()), 32'd0);
    apply_reset();
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h11 + 8'(i));
    send_msg(0, 5, 40'h15_14_13_12_11);
    chk("resend_starts", 32'(start_cnt - s0), 32'd5);

    repeat (5) @(posedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
